mips_multicycle_ctrl: RTL

Main control FSM for the multicycle MIPS datapath. Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback. Drives every datapath enable, plus the 2-bit alu_ctrl class code consumed by the ALU-function decoder, which turns func into the final ALU op. Also waits on memory through a ready handshake and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 116 +++++++++++
 rtl/mips_multicycle_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes,
// ALU class codes, FSM states, datapath mux selects and the per-state
// control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Class code handed to the ALU-function decoder; 2'b11 is reserved.
    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_FUNC = 2'b10
    } alu_ctrl_t;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;

    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REG     = 1'b1;
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH  = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore part of the control word; pc_write and branch are combined
    // with mem_ready / zero outside the register to form pc_en.
    typedef struct packed {
        alu_ctrl_t  alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // Control word asserted while the FSM sits in state s.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            S_DECODE:  c.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_RTYPEEX: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                c.alu_ctrl  = ALU_FUNC;
            end
            S_RTYPEWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                c.alu_ctrl  = ALU_SUB;
                c.branch    = 1'b1;
                c.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:  c.reg_write = 1'b1;
            S_JEX: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, stalls on the
// memory ready handshake and counts retired instructions.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_ctrl,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   ready;
    logic   retire;

    assign ready = USE_MEM_READY ? mem_ready : 1'b1;

    // Next-state selection and detection of an instruction completing.
    always_comb begin
        next_state = S_FETCH;
        retire     = 1'b0;
        case (state)
            S_IDLE:    next_state = S_FETCH;
            S_FETCH:   next_state = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                next_state = ready ? S_FETCH : S_MEMWR;
                retire     = ready;
            end
            S_RTYPEEX: next_state = S_RTYPEWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default:   next_state = S_FETCH;
        endcase
    end

    // State, registered control word for the coming state, and the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ctrl_q    <= '0;
            instr_cnt <= '0;
        end else begin
            state  <= next_state;
            ctrl_q <= decode_state(next_state);
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    assign alu_ctrl   = ctrl_q.alu_ctrl;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign pc_src     = ctrl_q.pc_src;
    assign iord       = ctrl_q.iord;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;

    // The fetch-side PC and IR loads wait for memory; jumps do not.
    assign ir_write   = ctrl_q.ir_write & ready;
    assign pc_en      = (ctrl_q.pc_write & (ready | (state != S_FETCH))) |
                        (ctrl_q.branch & zero);
    assign illegal_op = (state == S_DECODE) && !is_legal(opcode);

endmodule
